// File: rtl/l1_pkg.sv
// -----------------------------------------------------------------------------
// l1_pkg
// Shared definitions for the L1 loss pipeline (per-sample loss stage and the
// batch-mean stage): fixed-point format, the loss word type and the
// batch-mean controller states.
// -----------------------------------------------------------------------------
package l1_pkg;

   localparam int IL = 8;   // integer bits of the fixed-point loss
   localparam int FL = 12;  // fraction bits of the fixed-point loss

   typedef logic signed [IL+FL-1:0] fixed_t;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DIVIDE,
      DONE
   } state_t;

endpackage

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Unsigned restoring divider, one quotient bit per clock, MSB first.
// A start pulse loads the dividend. W cycles later done pulses for one cycle
// and quotient holds the result until the next start. The remainder is kept
// internally only.
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   start        load dividend and begin a division (priority over stepping)
//   dividend     W-bit unsigned dividend, sampled on start
//   divisor      W-bit unsigned divisor, must stay stable during the division
//   done         one-cycle pulse; quotient is final from this cycle on
//   quotient     W-bit unsigned quotient
// -----------------------------------------------------------------------------
module seq_divider #(
   parameter int W = 27
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic         done,
   output logic [W-1:0] quotient
);

   localparam int CW = $clog2(W+1);

   logic [W-1:0]  rem;
   logic [CW-1:0] bits_left;
   logic [W:0]    rem_shift;   // partial remainder with the next dividend bit
   logic [W-1:0]  rem_sub;

   // The quotient register doubles as the dividend shift register: its MSB
   // feeds the partial remainder while quotient bits enter at the LSB.
   always_comb begin
      rem_shift = {rem, quotient[W-1]};
      // Only used when rem_shift >= divisor, so the difference fits in W bits.
      rem_sub   = rem_shift[W-1:0] - divisor;
   end

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         rem       <= '0;
         quotient  <= '0;
         bits_left <= '0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            quotient  <= dividend;
            rem       <= '0;
            bits_left <= CW'(W);
         end else if (bits_left != '0) begin
            if (rem_shift >= {1'b0, divisor}) begin
               rem      <= rem_sub;
               quotient <= {quotient[W-2:0], 1'b1};
            end else begin
               rem      <= rem_shift[W-1:0];
               quotient <= {quotient[W-2:0], 1'b0};
            end
            bits_left <= bits_left - CW'(1);
            done      <= (bits_left == CW'(1));
         end
      end
   end

endmodule

// File: rtl/l1_batch_mean.sv
// -----------------------------------------------------------------------------
// l1_batch_mean
// Accumulates one L1 loss per sample over a batch and returns the batch mean
// (truncated toward zero) through a valid/ready output.
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   start        begins a batch; honoured only in IDLE
//   batch_size   number of samples, sampled on start
//   loss_valid   loss_in is valid
//   loss_in      signed per-sample loss (negative values count as 0)
//   loss_ready   sample accepted this cycle when loss_valid is high
//   mean_valid   mean_out is valid
//   mean_out     signed batch mean
//   mean_ready   consumer accepts mean_out
//   busy         high in any state other than IDLE
//   err_zero     sticky: start seen with batch_size == 0
//   err_neg      sticky: a negative loss was accepted
// -----------------------------------------------------------------------------
module l1_batch_mean #(
   parameter int IL        = l1_pkg::IL,
   parameter int FL        = l1_pkg::FL,
   parameter int BATCH_MAX = 64,
   parameter int BW        = $clog2(BATCH_MAX+1),
   parameter int ACCW      = IL + FL + BW
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [BW-1:0]           batch_size,
   input  logic                    loss_valid,
   input  logic signed [IL+FL-1:0] loss_in,
   output logic                    loss_ready,
   output logic                    mean_valid,
   output logic signed [IL+FL-1:0] mean_out,
   input  logic                    mean_ready,
   output logic                    busy,
   output logic                    err_zero,
   output logic                    err_neg
);

   import l1_pkg::*;

   state_t            state, next_state;
   logic [ACCW-1:0]   acc;
   logic [ACCW-1:0]   acc_next;
   logic [BW-1:0]     count;
   logic [BW-1:0]     bsize;
   logic              accept;
   logic              last_sample;
   logic              div_done;
   logic [ACCW-1:0]   div_quotient;
   logic              unused_quot_hi;

   assign accept      = loss_valid && loss_ready;
   assign last_sample = accept && ((count + BW'(1)) == bsize);

   // Negative losses are clamped to zero before accumulation.
   assign acc_next = acc + (loss_in[IL+FL-1] ? '0 : {{(ACCW-IL-FL){1'b0}}, loss_in});

   // The mean never exceeds the largest sample, so the upper quotient bits
   // are always zero and are not carried to mean_out.
   assign unused_quot_hi = ^div_quotient[ACCW-1:IL+FL];

   // The divider is launched on the edge that accepts the final sample, using
   // the sum that includes it; it then needs ACCW cycles in DIVIDE.
   seq_divider #(
      .W(ACCW)
   ) u_div (
      .clk      (clk),
      .reset    (reset),
      .start    (last_sample),
      .dividend (acc_next),
      .divisor  ({{(ACCW-BW){1'b0}}, bsize}),
      .done     (div_done),
      .quotient (div_quotient)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // Next-state logic
   // NOTE: next_state gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start)       next_state = (batch_size == '0) ? DONE : ACCUM;
         ACCUM:   if (last_sample) next_state = DIVIDE;
         DIVIDE:  if (div_done)    next_state = DONE;
         DONE:    if (mean_ready)  next_state = IDLE;
         default:                  next_state = IDLE;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      loss_ready = (state == ACCUM);
      mean_valid = (state == DONE);
      busy       = (state != IDLE);
   end

   // Batch datapath and sticky error flags
   always_ff @(posedge clk) begin
      if (reset) begin
         acc      <= '0;
         count    <= '0;
         bsize    <= '0;
         mean_out <= '0;
         err_zero <= 1'b0;
         err_neg  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  bsize    <= batch_size;
                  acc      <= '0;
                  count    <= '0;
                  err_neg  <= 1'b0;
                  err_zero <= (batch_size == '0);
                  if (batch_size == '0) mean_out <= '0;
               end
            end
            ACCUM: begin
               if (accept) begin
                  acc   <= acc_next;
                  count <= count + BW'(1);
                  if (loss_in[IL+FL-1]) err_neg <= 1'b1;
               end
            end
            DIVIDE: begin
               if (div_done) mean_out <= div_quotient[IL+FL-1:0];
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_l1_batch_mean.sv
// -----------------------------------------------------------------------------
// tb_l1_batch_mean
// Directed stimulus for l1_batch_mean. Each batch pushes its hand-computed
// result onto a scoreboard queue; an independent monitor pops and compares
// whenever a mean_valid/mean_ready transfer occurs.
// -----------------------------------------------------------------------------
module tb_l1_batch_mean;

   localparam int IL = 8;
   localparam int FL = 12;
   localparam int BW = 7;

   typedef struct packed {
      logic [IL+FL-1:0] mean;
      logic             ez;
      logic             en;
   } exp_t;

   logic                    clk = 1'b0;
   logic                    reset;
   logic                    start;
   logic [BW-1:0]           batch_size;
   logic                    loss_valid;
   logic signed [IL+FL-1:0] loss_in;
   logic                    loss_ready;
   logic                    mean_valid;
   logic signed [IL+FL-1:0] mean_out;
   logic                    mean_ready;
   logic                    busy;
   logic                    err_zero;
   logic                    err_neg;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   l1_batch_mean dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .batch_size (batch_size),
      .loss_valid (loss_valid),
      .loss_in    (loss_in),
      .loss_ready (loss_ready),
      .mean_valid (mean_valid),
      .mean_out   (mean_out),
      .mean_ready (mean_ready),
      .busy       (busy),
      .err_zero   (err_zero),
      .err_neg    (err_neg)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: bound expired", name);
   endtask

   // Entered and left at posedge+1.
   task automatic start_batch(input logic [BW-1:0] bs);
      start      = 1'b1;
      batch_size = bs;
      @(posedge clk); #1;
      start      = 1'b0;
   endtask

   task automatic send(input logic [IL+FL-1:0] v);
      int n = 0;
      loss_valid = 1'b1;
      loss_in    = v;
      while (!loss_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!loss_ready) fail("loss_ready_timeout");
      @(posedge clk); #1;
      loss_valid = 1'b0;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!mean_valid && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (!mean_valid) fail("mean_valid_timeout");
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (busy) fail("idle_timeout");
   endtask

   // Scoreboard monitor: a transfer happens on the next edge when both are high.
   always @(negedge clk) begin
      if (!reset && mean_valid && mean_ready) begin
         if (sb.size() == 0) begin
            fail("unexpected_mean");
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("mean_out", {12'd0, mean_out}, {12'd0, e.mean});
            check("err_zero", {31'd0, err_zero}, {31'd0, e.ez});
            check("err_neg",  {31'd0, err_neg},  {31'd0, e.en});
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not end");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int held;

      reset      = 1'b1;
      start      = 1'b0;
      batch_size = '0;
      loss_valid = 1'b0;
      loss_in    = '0;
      mean_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_loss_ready", {31'd0, loss_ready}, 0);
      check("rst_mean_valid", {31'd0, mean_valid}, 0);
      check("rst_mean_out",   {12'd0, mean_out},   0);
      check("rst_busy",       {31'd0, busy},       0);
      check("rst_err_zero",   {31'd0, err_zero},   0);
      check("rst_err_neg",    {31'd0, err_neg},    0);
      reset = 1'b0;
      @(posedge clk); #1;

      // 1.0, 2.0, 3.0, 4.0 -> 2.5, with latency measurement
      sb.push_back('{mean: 20'd10240, ez: 1'b0, en: 1'b0});
      start_batch(7'd4);
      check("busy_accum", {31'd0, busy}, 1);
      send(20'd4096);
      send(20'd8192);
      send(20'd12288);
      send(20'd16384);
      check("loss_ready_drop", {31'd0, loss_ready}, 0);
      wait_valid(n);
      check("latency", n, 28);
      wait_idle();

      // 1,1,2 -> 4/3 truncates to 1; a start during ACCUM is ignored
      sb.push_back('{mean: 20'd1, ez: 1'b0, en: 1'b0});
      start_batch(7'd3);
      send(20'd1);
      start_batch(7'd0);
      send(20'd1);
      send(20'd2);
      wait_idle();

      // zero batch size: result in the next cycle
      sb.push_back('{mean: 20'd0, ez: 1'b1, en: 1'b0});
      start_batch(7'd0);
      check("zero_mean_valid", {31'd0, mean_valid}, 1);
      check("zero_mean_out",   {12'd0, mean_out},   0);
      check("zero_err_zero",   {31'd0, err_zero},   1);
      wait_idle();

      // back-pressure: result held while mean_ready is low
      mean_ready = 1'b0;
      sb.push_back('{mean: 20'h7FFFF, ez: 1'b0, en: 1'b0});
      start_batch(7'd2);
      send(20'h7FFFF);
      send(20'h7FFFF);
      wait_valid(n);
      held = 0;
      for (int i = 0; i < 10; i++) begin
         if (mean_valid && mean_out == 20'sh7FFFF) held++;
         @(posedge clk); #1;
      end
      check("hold_cycles", held, 10);
      mean_ready = 1'b1;
      @(posedge clk); #1;
      check("post_xfer_valid", {31'd0, mean_valid}, 0);
      check("post_xfer_busy",  {31'd0, busy},       0);

      // negative sample clamps to zero and raises err_neg
      sb.push_back('{mean: 20'd2048, ez: 1'b0, en: 1'b1});
      start_batch(7'd2);
      send(20'hFFFFF);
      check("neg_err_flag", {31'd0, err_neg}, 1);
      send(20'd4096);
      wait_idle();

      // reset in the middle of a batch abandons it
      start_batch(7'd4);
      send(20'hFFFFF);
      send(20'd4096);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("mid_rst_loss_ready", {31'd0, loss_ready}, 0);
      check("mid_rst_mean_valid", {31'd0, mean_valid}, 0);
      check("mid_rst_mean_out",   {12'd0, mean_out},   0);
      check("mid_rst_busy",       {31'd0, busy},       0);
      check("mid_rst_err_neg",    {31'd0, err_neg},    0);
      sb.push_back('{mean: 20'd4096, ez: 1'b0, en: 1'b0});
      start_batch(7'd2);
      send(20'd4096);
      send(20'd4096);
      wait_idle();

      repeat (5) @(posedge clk);
      #1;
      check("scoreboard_drained", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/l1_batch_mean.md
Name: l1_batch_mean

Overview:
- Sits directly downstream of the per-sample L1 loss stage. Consumes one L1 loss sum per sample and accumulates a batch of them.
- Computes the batch mean loss with a sequential restoring divider, then presents it to the training controller and loss logger.
- Valid/ready handshakes on both input and output sides. Same signed fixed-point format as the loss stage (IL integer bits, FL fraction bits).

Parameters:
- IL, 8, integer bits of fixed-point loss.
- FL, 12, fraction bits of fixed-point loss.
- BATCH_MAX, 64, largest supported batch size.
- BW, $clog2(BATCH_MAX+1), width of batch_size and the sample counter.
- ACCW, IL+FL+BW, accumulator, dividend and quotient width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a batch. Honoured only in IDLE.
- batch_size  in  BW  number of samples in the batch, sampled on start.
- loss_valid  in  1  loss_in is valid.
- loss_in  in  IL+FL signed  per-sample L1 loss.
- loss_ready  out  1  block accepts a sample this cycle.
- mean_valid  out  1  mean_out is valid.
- mean_out  out  IL+FL signed  batch mean loss.
- mean_ready  in  1  consumer accepts mean_out.
- busy  out  1  high in any state other than IDLE.
- err_zero  out  1  sticky: start was seen with batch_size==0.
- err_neg  out  1  sticky: a negative loss_in was accepted.

Behaviour:
- Reset. On reset=1 at a clock edge:
  - state<=IDLE.
  - acc, count, quotient and remainder all <=0.
  - loss_ready=0, mean_valid=0, mean_out=0, busy=0, err_zero=0, err_neg=0.
  - Reset mid-operation abandons the batch; no partial result is ever emitted.
- State IDLE:
  - start with batch_size>0: latch batch_size, clear acc and count, go to ACCUM.
  - start with batch_size==0: set err_zero, mean_out<=0, go to DONE.
  - start is ignored in every other state.
- State ACCUM:
  - loss_ready=1 only in this state.
  - A sample is accepted on loss_valid&&loss_ready.
  - Accepted sample: acc<=acc+zero-extended loss_in, count<=count+1.
  - Negative loss_in (MSB=1) is accumulated as 0 and sets err_neg.
  - When the accepted sample makes count==batch_size, go to DIVIDE on the next edge. loss_ready drops in that same next cycle.
  - No overflow is possible: acc ≤ BATCH_MAX·(2^(IL+FL-1)-1) < 2^ACCW.
- State DIVIDE:
  - Unsigned restoring division acc / batch_size.
  - One quotient bit per cycle, MSB first, exactly ACCW cycles.
  - Result truncates toward zero; the remainder is discarded.
  - The quotient never exceeds the largest input, so bits above IL+FL-1 are zero. mean_out takes quotient[IL+FL-1:0].
  - After the final bit, go to DONE.
- State DONE:
  - mean_valid=1.
  - mean_out is held stable until mean_valid&&mean_ready, then go to IDLE with mean_valid=0.
  - A transfer takes place in the first DONE cycle if mean_ready is already high.
- Latency:
  - From acceptance of the last sample to mean_valid=1 is ACCW+1 cycles (27+1=28 at defaults).
  - From start (batch_size==0) to mean_valid=1 is 1 cycle.
- Error flags: err_zero and err_neg are cleared only by reset or by the next accepted start.
- Simultaneous events: start is ignored while a handshake completes in DONE; it takes effect only once in IDLE.

Decomposition:
- Package l1_pkg holds:
  - IL, FL.
  - typedef fixed_t (signed [IL+FL-1:0]).
  - enum state_t {IDLE, ACCUM, DIVIDE, DONE}.
  - The l1 loss stage imports the same package.
- One sub-module, seq_divider: unsigned restoring divider.
  - Parameter W.
  - Ports: start, dividend, divisor, done, quotient.
  - Owned and sequenced by the top-level FSM.

Test Plan:
- batch_size=4, losses 4096,8192,12288,16384 (1.0, 2.0, 3.0, 4.0) -> mean_out=10240 (2.5), mean_valid exactly 28 cycles after the 4th accept.
- batch_size=3, losses 1,1,2 -> mean_out=1 (truncation), err flags 0.
- start with batch_size=0 -> next cycle mean_valid=1, mean_out=0, err_zero=1.
- batch_size=2, losses 0x7FFFF,0x7FFFF, mean_ready held low 10 cycles -> mean_out stays 0x7FFFF and mean_valid stays high until mean_ready=1, then IDLE.
- batch_size=2, losses 0xFFFFF (negative), 4096 -> err_neg=1, mean_out=2048.
- Reset asserted after 2 of 4 samples -> all outputs 0 and IDLE next cycle. A new batch of 2×4096 -> mean_out=4096.
